// File: rtl/vmem_pkg.sv
// vmem_pkg: shared widths, slot phase numbers and FSM encoding for the video RAM arbiter
package vmem_pkg;
  localparam int VM_AW = 14;
  localparam int VM_DW = 8;
  localparam logic [1:0] PH_VID_ADDR  = 2'd2;
  localparam logic [1:0] PH_VID_CAP   = 2'd0;
  localparam logic [1:0] PH_CPU_ISSUE = 2'd0;
  localparam logic [1:0] PH_CPU_CAP   = 2'd2;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RD_QUEUED = 2'd1;
  localparam logic [1:0] S_RD_ISSUED = 2'd2;
endpackage

// File: rtl/vmem_arbiter_if.sv
// vmem_arbiter_if: CPU request/ack bus (req/we/addr/wdata from master, rdata/ack from arbiter)
interface vmem_arbiter_if import vmem_pkg::*; #(parameter int AW = VM_AW, parameter int DW = VM_DW);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  modport master(output req, we, addr, wdata, input rdata, ack);
  modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/vmem_wbuf.sv
// vmem_wbuf: one-entry posted-write buffer; ports clock/rst_n, load (+load_addr/load_data), drain, valid/addr/data out
module vmem_wbuf #(parameter int AW = 14, parameter int DW = 8) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  // a load on the drain edge refills the entry, so load wins over drain
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      valid <= load || (valid && !drain);
      if (load) begin
        addr <= load_addr;
        data <= load_data;
      end
    end
endmodule

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: 4-phase slot arbiter sharing one video BRAM port between the adapter and the CPU
// ports: clock/rst_n; phase (phase[1] = pixel clock); vaddr/vdata video stream;
//        cpu (slave modport of vmem_arbiter_if); mem_addr/mem_wdata/mem_we/mem_rdata to the BRAM
module vmem_arbiter import vmem_pkg::*; #(parameter int AW = VM_AW, parameter int DW = VM_DW) (
  input  logic          clock,
  input  logic          rst_n,
  output logic [1:0]    phase,
  input  logic [AW-1:0] vaddr,
  output logic [DW-1:0] vdata,
  vmem_arbiter_if.slave cpu,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  logic [1:0]    state;
  logic [AW-1:0] rd_addr;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          accept, drain, wr_load, rd_issue, rd_done;
  // a request is only looked at while idle and outside the ack cycle
  assign accept   = cpu.req && state == S_IDLE && !cpu.ack;
  assign drain    = phase == PH_CPU_ISSUE && wb_valid;
  assign wr_load  = accept && cpu.we && (!wb_valid || drain);
  assign rd_issue = phase == PH_CPU_ISSUE && state == S_RD_QUEUED;
  assign rd_done  = phase == PH_CPU_CAP && state == S_RD_ISSUED;
  vmem_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
    .clock(clock), .rst_n(rst_n), .load(wr_load), .drain(drain),
    .load_addr(cpu.addr), .load_data(cpu.wdata),
    .valid(wb_valid), .addr(wb_addr), .data(wb_data)
  );
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      phase <= '0;
      vdata <= '0;
      cpu.rdata <= '0;
      cpu.ack <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      state <= S_IDLE;
      rd_addr <= '0;
    end else begin
      phase <= phase + 2'd1;
      // write strobe lives only in phase 1, right after a drain slot
      mem_we <= drain;
      cpu.ack <= wr_load || rd_done;
      if (phase == PH_VID_ADDR) mem_addr <= vaddr;
      if (phase == PH_VID_CAP) vdata <= mem_rdata;
      // buffered write beats a queued read so reads always see older writes
      if (drain) begin
        mem_addr <= wb_addr;
        mem_wdata <= wb_data;
      end else if (rd_issue) begin
        mem_addr <= rd_addr;
        state <= S_RD_ISSUED;
      end
      if (rd_done) begin
        cpu.rdata <= mem_rdata;
        state <= S_IDLE;
      end
      if (accept && !cpu.we) begin
        rd_addr <= cpu.addr;
        state <= S_RD_QUEUED;
      end
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: directed + random checks of vmem_arbiter against a RAM-content/slot-timing model
module tb_vmem_arbiter;
  logic        clock = 0;
  logic        rst_n = 1;
  logic [1:0]  phase;
  logic [13:0] vaddr = 14'h1234;
  logic [7:0]  vdata;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 0;
  logic        mem_we;
  logic        pl_en = 0;
  logic [13:0] pl_addr = 0;
  logic [7:0]  pl_data = 0;
  logic [7:0]  ram [16384];
  logic [7:0]  model [16384];

  vmem_arbiter_if #(.AW(14), .DW(8)) bus();

  vmem_arbiter dut (
    .clock(clock), .rst_n(rst_n), .phase(phase), .vaddr(vaddr), .vdata(vdata),
    .cpu(bus.slave), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // synchronous read-first BRAM, with a preload path used only while in reset
  always @(posedge clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [1:0]  ph = 0;
  logic        vid_arm = 0, vid_have = 0, vid_rand = 0;
  logic [13:0] vid_lat = 0;
  logic [7:0]  vid_exp = 0;
  logic [21:0] wq[$];
  int          land_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; checks phase, video captures and every RAM write strobe
  task automatic tick();
    logic [21:0] w;
    if (ph == 2'd2) begin
      if (vid_rand) vaddr = 14'h3000 + 14'($urandom_range(0, 31));
      vid_lat = vaddr;
      vid_arm = 1;
    end
    if (ph == 2'd0 && vid_arm) begin
      vid_exp = model[vid_lat];
      vid_have = 1;
    end
    @(negedge clock);
    ph = ph + 2'd1;
    cyc++;
    chk("phase", 32'(phase), 32'(ph));
    if (ph == 2'd1 && vid_have) chk("vdata", 32'(vdata), 32'(vid_exp));
    if (mem_we) begin
      chk("we_phase", 32'(phase), 1);
      if (wq.size() == 0) chk("we_unexpected", 32'(mem_we), 0);
      else begin
        w = wq.pop_front();
        chk("we_addr", 32'(mem_addr), 32'(w[21:8]));
        chk("we_data", 32'(mem_wdata), 32'(w[7:0]));
        land_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic wait_ph(input logic [1:0] p);
    for (int i = 0; i < 8 && ph != p; i++) tick();
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1;
    model[a] = d;
    @(negedge clock);
  endtask

  // edge i (1-based) after the request ends phase (ph+i-1)%4; a full buffer grabs the first phase-0 slot
  task automatic cpu_write(input logic [13:0] a, input logic [7:0] d, output int lat);
    int e;
    e = (wq.size() == 0) ? 1 : ((4 - int'(ph)) % 4) + 1;
    bus.req = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
    lat = 0;
    do begin tick(); lat++; end while (!bus.ack && lat < 20);
    bus.req = 0;
    chk("wr_lat", lat, e);
    model[a] = d;
    wq.push_back({a, d});
    tick();
    chk("wr_ack_pulse", 32'(bus.ack), 0);
  endtask

  task automatic cpu_read(input logic [13:0] a, output int lat);
    int wd, iss, e;
    logic pend;
    pend = wq.size() != 0;
    wd = 0; iss = 0; e = 0;
    for (int i = 1; i < 16; i++) begin
      int p;
      p = (int'(ph) + i - 1) % 4;
      if (p == 0 && pend && wd == 0) wd = i;
      else if (p == 0 && i > 1 && iss == 0) iss = i;
      else if (p == 2 && iss != 0 && e == 0) e = i;
    end
    bus.req = 1; bus.we = 0; bus.addr = a; bus.wdata = 0;
    lat = 0;
    do begin tick(); lat++; end while (!bus.ack && lat < 20);
    bus.req = 0;
    chk("rd_lat", lat, e);
    chk("rd_data", 32'(bus.rdata), 32'(model[a]));
    tick();
    chk("rd_ack_pulse", 32'(bus.ack), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [13:0] a;
    logic [7:0] old;
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_vdata", 32'(vdata), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    @(negedge clock);
    preload(14'h1234, 8'hA5);
    preload(14'h0300, 8'h99);
    for (int i = 0; i < 64; i++) preload(14'(i), 8'($urandom));
    for (int i = 0; i < 32; i++) preload(14'h3000 + 14'(i), 8'($urandom));
    pl_en = 0;
    rst_n = 1;
    ph = 0;

    // video stream from a preloaded address, no CPU traffic
    for (int i = 0; i < 12 && !(vid_have && ph == 2'd1); i++) tick();
    for (int i = 0; i < 4; i++) begin
      chk("vid_stable", 32'(vdata), 8'hA5);
      chk("vid_no_we", 32'(mem_we), 0);
      tick();
    end

    // single write from phase 2, then read it back
    wait_ph(2);
    cpu_write(14'h0100, 8'h3C, lat);
    for (int i = 0; i < 8 && wq.size() != 0; i++) tick();
    chk("wr1_landed", wq.size(), 0);
    cpu_read(14'h0100, lat);

    // back-to-back writes: second waits for the drain edge, lands one slot later
    wait_ph(0);
    land_cyc.delete();
    cpu_write(14'h0100, 8'h44, lat);
    cpu_write(14'h0101, 8'h77, lat);
    chk("b2b_second_lat", lat, 3);
    for (int i = 0; i < 12 && wq.size() != 0; i++) tick();
    chk("b2b_lands", land_cyc.size(), 2);
    if (land_cyc.size() == 2) chk("b2b_gap", land_cyc[1] - land_cyc[0], 4);

    // read-after-write to the same address
    wait_ph(0);
    cpu_write(14'h0200, 8'h5A, lat);
    cpu_read(14'h0200, lat);
    chk("raw_lat", lat, 9);

    // continuous CPU reads while the video address moves every slot
    vid_rand = 1;
    for (int i = 0; i < 20; i++) cpu_read(14'($urandom_range(0, 63)), lat);

    // random mix of reads and writes with random gaps
    for (int i = 0; i < 60; i++) begin
      a = 14'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) cpu_write(a, 8'($urandom), lat);
      else cpu_read(a, lat);
      repeat ($urandom_range(0, 2)) tick();
    end
    vid_rand = 0;
    for (int i = 0; i < 12 && wq.size() != 0; i++) tick();

    // reset with a buffered write and a queued read
    wait_ph(0);
    old = model[14'h0300];
    cpu_write(14'h0300, 8'hEE, lat);
    bus.req = 1; bus.we = 0; bus.addr = 14'h0000;
    tick();
    bus.req = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_phase", 32'(phase), 0);
    chk("mid_rst_vdata", 32'(vdata), 0);
    chk("mid_rst_rdata", 32'(bus.rdata), 0);
    chk("mid_rst_ack", 32'(bus.ack), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_mem_wdata", 32'(mem_wdata), 0);
    chk("mid_rst_mem_we", 32'(mem_we), 0);
    model[14'h0300] = old;
    wq.delete();
    @(negedge clock);
    @(negedge clock);
    rst_n = 1;
    ph = 0;
    vid_arm = 0;
    vid_have = 0;
    for (int i = 0; i < 8; i++) tick();
    cpu_read(14'h0300, lat);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
